// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: prioritised bus mux, register set, and a
// 5-bit-opcode ALU whose 64-bit result lands in Z.
module data_path (
    input  logic        clk,
    input  logic        clr,
    input  logic        pc_out,
    input  logic        zlo_out,
    input  logic        zhi_out,
    input  logic        mdr_out,
    input  logic        r2_out,
    input  logic        r3_out,
    input  logic        r4_out,
    input  logic        r6_out,
    input  logic        r7_out,
    input  logic        pc_enable,
    input  logic        mar_enable,
    input  logic        mdr_enable,
    input  logic        ir_enable,
    input  logic        y_enable,
    input  logic        z_enable,
    input  logic        hi_enable,
    input  logic        lo_enable,
    input  logic        r2_enable,
    input  logic        r3_enable,
    input  logic        r4_enable,
    input  logic        r6_enable,
    input  logic        r7_enable,
    input  logic        pc_increment,
    input  logic        read,
    input  logic [4:0]  op_code,
    input  logic [31:0] m_data_in,
    output logic [31:0] bus_q,
    output logic [31:0] pc_q,
    output logic [31:0] mar_q,
    output logic [31:0] mdr_q,
    output logic [31:0] ir_q,
    output logic [31:0] y_q,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] r2_q,
    output logic [31:0] r3_q,
    output logic [31:0] r4_q,
    output logic [31:0] r6_q,
    output logic [31:0] r7_q,
    output logic [63:0] z_q
);
    localparam int unsigned DW = 32;
    localparam int unsigned ZW = 64;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [DW-1:0] r_pc, r_mar, r_mdr, r_ir, r_y, r_hi, r_lo;
    logic [DW-1:0] r_r2, r_r3, r_r4, r_r6, r_r7;
    logic [ZW-1:0] r_z;

    logic [DW-1:0]        w_bus;
    logic [DW-1:0]        w_mdr_in;
    logic [ZW-1:0]        w_alu;
    logic [4:0]           w_shamt;
    logic [2*DW-1:0]      w_rot_r;
    logic [2*DW-1:0]      w_rot_l;
    logic signed [ZW-1:0] w_mul_a;
    logic signed [ZW-1:0] w_mul_b;
    logic signed [ZW-1:0] w_mul;
    logic signed [DW-1:0] w_sa;
    logic signed [DW-1:0] w_sb;
    logic [DW-1:0]        w_div_q;
    logic [DW-1:0]        w_div_r;

    // Fixed-priority bus source select; idle bus reads as zero
    always_comb begin
        w_bus = '0;
        if      (pc_out)  w_bus = r_pc;
        else if (zlo_out) w_bus = r_z[DW-1:0];
        else if (zhi_out) w_bus = r_z[ZW-1:DW];
        else if (mdr_out) w_bus = r_mdr;
        else if (r2_out)  w_bus = r_r2;
        else if (r3_out)  w_bus = r_r3;
        else if (r4_out)  w_bus = r_r4;
        else if (r6_out)  w_bus = r_r6;
        else if (r7_out)  w_bus = r_r7;
    end

    assign w_mdr_in = read ? m_data_in : w_bus;
    assign w_shamt  = w_bus[4:0];
    assign w_rot_r  = {r_y, r_y} >> w_shamt;
    assign w_rot_l  = {r_y, r_y} << w_shamt;
    assign w_sa     = r_y;
    assign w_sb     = w_bus;
    assign w_mul_a  = {{DW{r_y[DW-1]}}, r_y};
    assign w_mul_b  = {{DW{w_bus[DW-1]}}, w_bus};
    assign w_mul    = w_mul_a * w_mul_b;

    // Signed divide; zero divisor and INT_MIN/-1 are pinned to defined results
    always_comb begin
        w_div_q = '0;
        w_div_r = '0;
        if (w_bus == '0) begin
            w_div_q = '1;
            w_div_r = r_y;
        end else if (r_y == 32'h8000_0000 && w_bus == '1) begin
            w_div_q = r_y;
            w_div_r = '0;
        end else begin
            w_div_q = DW'(w_sa / w_sb);
            w_div_r = DW'(w_sa % w_sb);
        end
    end

    always_comb begin
        w_alu = '0;
        case (op_code)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI:
                w_alu = {32'd0, DW'(r_y + w_bus)};
            OP_SUB:          w_alu = {32'd0, DW'(r_y - w_bus)};
            OP_AND, OP_ANDI: w_alu = {32'd0, r_y & w_bus};
            OP_OR, OP_ORI:   w_alu = {32'd0, r_y | w_bus};
            OP_ROR:          w_alu = {32'd0, w_rot_r[DW-1:0]};
            OP_ROL:          w_alu = {32'd0, w_rot_l[2*DW-1:DW]};
            OP_SHR:          w_alu = {32'd0, r_y >> w_shamt};
            OP_SHRA:         w_alu = {32'd0, DW'(w_sa >>> w_shamt)};
            OP_SHL:          w_alu = {32'd0, r_y << w_shamt};
            OP_DIV:          w_alu = {w_div_r, w_div_q};
            OP_MUL:          w_alu = w_mul;
            OP_NEG:          w_alu = {32'd0, DW'(32'd0 - w_bus)};
            OP_NOT:          w_alu = {32'd0, ~w_bus};
            default:         w_alu = '0;
        endcase
    end

    // Register file; clr overrides every enable
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_ir  <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_r2  <= '0;
            r_r3  <= '0;
            r_r4  <= '0;
            r_r6  <= '0;
            r_r7  <= '0;
        end else begin
            if (pc_enable)         r_pc <= w_bus;
            else if (pc_increment) r_pc <= r_pc + 32'd1;
            if (mar_enable) r_mar <= w_bus;
            if (mdr_enable) r_mdr <= w_mdr_in;
            if (ir_enable)  r_ir  <= w_bus;
            if (y_enable)   r_y   <= w_bus;
            if (z_enable)   r_z   <= w_alu;
            if (hi_enable)  r_hi  <= w_bus;
            if (lo_enable)  r_lo  <= w_bus;
            if (r2_enable)  r_r2  <= w_bus;
            if (r3_enable)  r_r3  <= w_bus;
            if (r4_enable)  r_r4  <= w_bus;
            if (r6_enable)  r_r6  <= w_bus;
            if (r7_enable)  r_r7  <= w_bus;
        end
    end

    assign bus_q = w_bus;
    assign pc_q  = r_pc;
    assign mar_q = r_mar;
    assign mdr_q = r_mdr;
    assign ir_q  = r_ir;
    assign y_q   = r_y;
    assign hi_q  = r_hi;
    assign lo_q  = r_lo;
    assign r2_q  = r_r2;
    assign r3_q  = r_r3;
    assign r4_q  = r_r4;
    assign r6_q  = r_r6;
    assign r7_q  = r_r7;
    assign z_q   = r_z;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: register transfers, ALU ops, bus priority, reset.
module tb_data_path;
    logic        clk = 1'b0;
    logic        clr;
    logic        pc_out, zlo_out, zhi_out, mdr_out, r2_out, r3_out, r4_out, r6_out, r7_out;
    logic        pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable, hi_enable, lo_enable;
    logic        r2_enable, r3_enable, r4_enable, r6_enable, r7_enable;
    logic        pc_increment, read;
    logic [4:0]  op_code;
    logic [31:0] m_data_in;
    logic [31:0] bus_q, pc_q, mar_q, mdr_q, ir_q, y_q, hi_q, lo_q;
    logic [31:0] r2_q, r3_q, r4_q, r6_q, r7_q;
    logic [63:0] z_q;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]  alu_op  [12];
    logic [63:0] alu_exp [12];

    data_path dut (
        .clk(clk), .clr(clr),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
        .r2_out(r2_out), .r3_out(r3_out), .r4_out(r4_out), .r6_out(r6_out), .r7_out(r7_out),
        .pc_enable(pc_enable), .mar_enable(mar_enable), .mdr_enable(mdr_enable),
        .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
        .hi_enable(hi_enable), .lo_enable(lo_enable),
        .r2_enable(r2_enable), .r3_enable(r3_enable), .r4_enable(r4_enable),
        .r6_enable(r6_enable), .r7_enable(r7_enable),
        .pc_increment(pc_increment), .read(read), .op_code(op_code), .m_data_in(m_data_in),
        .bus_q(bus_q), .pc_q(pc_q), .mar_q(mar_q), .mdr_q(mdr_q), .ir_q(ir_q), .y_q(y_q),
        .hi_q(hi_q), .lo_q(lo_q), .r2_q(r2_q), .r3_q(r3_q), .r4_q(r4_q), .r6_q(r6_q),
        .r7_q(r7_q), .z_q(z_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr = 0; read = 0; op_code = 5'd0; m_data_in = 32'd0; pc_increment = 0;
        pc_out = 0; zlo_out = 0; zhi_out = 0; mdr_out = 0;
        r2_out = 0; r3_out = 0; r4_out = 0; r6_out = 0; r7_out = 0;
        pc_enable = 0; mar_enable = 0; mdr_enable = 0; ir_enable = 0;
        y_enable = 0; z_enable = 0; hi_enable = 0; lo_enable = 0;
        r2_enable = 0; r3_enable = 0; r4_enable = 0; r6_enable = 0; r7_enable = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        m_data_in = v; read = 1; mdr_enable = 1;
        tick();
    endtask

    initial begin
        alu_op[0]  = 5'b00111; alu_exp[0]  = 64'h0000_0000_C000_0000; // ror
        alu_op[1]  = 5'b01000; alu_exp[1]  = 64'h0000_0000_0000_0003; // rol
        alu_op[2]  = 5'b01001; alu_exp[2]  = 64'h0000_0000_4000_0000; // shr
        alu_op[3]  = 5'b01010; alu_exp[3]  = 64'h0000_0000_C000_0000; // shra
        alu_op[4]  = 5'b01011; alu_exp[4]  = 64'h0000_0000_0000_0002; // shl
        alu_op[5]  = 5'b00011; alu_exp[5]  = 64'h0000_0000_8000_0002; // add
        alu_op[6]  = 5'b00100; alu_exp[6]  = 64'h0000_0000_8000_0000; // sub
        alu_op[7]  = 5'b00101; alu_exp[7]  = 64'h0000_0000_0000_0001; // and
        alu_op[8]  = 5'b00110; alu_exp[8]  = 64'h0000_0000_8000_0001; // or
        alu_op[9]  = 5'b10001; alu_exp[9]  = 64'h0000_0000_FFFF_FFFF; // neg
        alu_op[10] = 5'b10011; alu_exp[10] = 64'h0000_0000_0000_0000; // unused
        alu_op[11] = 5'b10010; alu_exp[11] = 64'h0000_0000_FFFF_FFFE; // not

        idle();
        clr = 1;
        tick();
        chk("rst_pc", pc_q, 0);
        chk("rst_z", z_q, 0);
        chk("rst_bus", bus_q, 0);

        // Divide 0x22 / 3 through R2, R6, Y, Z, LO, HI
        mdr_load(32'h22);
        chk("mdr_read", mdr_q, 64'h22);
        mdr_out = 1; r2_enable = 1; tick();
        chk("r2_load", r2_q, 64'h22);
        mdr_load(32'h3);
        mdr_out = 1; r6_enable = 1; tick();
        chk("r6_load", r6_q, 64'h3);
        r2_out = 1; y_enable = 1; tick();
        chk("y_load", y_q, 64'h22);
        r6_out = 1; op_code = 5'b01111; z_enable = 1; tick();
        chk("div_z", z_q, 64'h0000_0001_0000_000B);
        zlo_out = 1; lo_enable = 1; tick();
        chk("lo_load", lo_q, 64'hB);
        zhi_out = 1; hi_enable = 1; tick();
        chk("hi_load", hi_q, 64'h1);

        // Fetch
        pc_out = 1; mar_enable = 1; pc_increment = 1; tick();
        chk("fetch_mar", mar_q, 0);
        chk("fetch_pc_inc", pc_q, 1);
        pc_out = 1; r4_enable = 1; tick();
        chk("fetch_r4", r4_q, 1);
        r4_out = 1; pc_enable = 1; pc_increment = 1; tick();
        chk("pc_en_prio", pc_q, 1);
        mdr_load(32'h7930_0000);
        mdr_out = 1; ir_enable = 1; tick();
        chk("ir_load", ir_q, 64'h7930_0000);

        // Signed mul/div
        mdr_load(32'hFFFF_FFF9);
        mdr_out = 1; y_enable = 1; tick();
        mdr_load(32'h2);
        mdr_out = 1; op_code = 5'b10000; z_enable = 1; tick();
        chk("mul_neg", z_q, 64'hFFFF_FFFF_FFFF_FFF2);
        mdr_out = 1; op_code = 5'b01111; z_enable = 1; tick();
        chk("div_neg", z_q, 64'hFFFF_FFFF_FFFF_FFFD);
        op_code = 5'b01111; z_enable = 1; tick();
        chk("div_zero", z_q, 64'hFFFF_FFF9_FFFF_FFFF);

        // ALU table with Y=0x80000001, B=1
        mdr_load(32'h8000_0001);
        mdr_out = 1; y_enable = 1; tick();
        mdr_load(32'h1);
        for (int i = 0; i < 12; i++) begin
            mdr_out = 1; op_code = alu_op[i]; z_enable = 1; tick();
            chk($sformatf("alu_op_%05b", alu_op[i]), z_q, alu_exp[i]);
        end

        // Bus priority (PC=1, Z={0,0xFFFFFFFE}, MDR=1, R2=0x22, R3=0)
        pc_out = 1; mdr_out = 1; #1;
        chk("prio_pc_mdr", bus_q, 64'h1);
        idle(); zlo_out = 1; mdr_out = 1; #1;
        chk("prio_zlo_mdr", bus_q, 64'hFFFF_FFFE);
        idle(); zhi_out = 1; mdr_out = 1; #1;
        chk("prio_zhi_mdr", bus_q, 0);
        idle(); r2_out = 1; r3_out = 1; r7_out = 1; #1;
        chk("prio_r2_r3", bus_q, 64'h22);
        idle(); #1;
        chk("bus_idle", bus_q, 0);

        // Read-before-write: MDR driving and reloading from the bus holds its value
        mdr_out = 1; mdr_enable = 1; pc_enable = 1; tick();
        chk("rbw_mdr", mdr_q, 64'h1);
        chk("rbw_pc", pc_q, 64'h1);

        // PC wrap
        mdr_load(32'hFFFF_FFFF);
        mdr_out = 1; pc_enable = 1; tick();
        chk("pc_max", pc_q, 64'hFFFF_FFFF);
        pc_increment = 1; tick();
        chk("pc_wrap", pc_q, 0);

        // Reset over active enables
        mdr_load(32'hA5A5_A5A5);
        mdr_out = 1; mar_enable = 1; ir_enable = 1; y_enable = 1; hi_enable = 1; lo_enable = 1;
        r2_enable = 1; r3_enable = 1; r4_enable = 1; r6_enable = 1; r7_enable = 1; pc_enable = 1;
        tick();
        mdr_out = 1; op_code = 5'b00011; z_enable = 1; tick();
        chk("pre_rst_z", z_q, 64'h0000_0000_4B4B_4B4A);
        clr = 1; mdr_out = 1; read = 1; m_data_in = 32'h1234; mdr_enable = 1;
        r2_enable = 1; y_enable = 1; z_enable = 1; pc_increment = 1; mar_enable = 1;
        tick();
        chk("clr_pc", pc_q, 0);
        chk("clr_mar", mar_q, 0);
        chk("clr_mdr", mdr_q, 0);
        chk("clr_ir", ir_q, 0);
        chk("clr_y", y_q, 0);
        chk("clr_z", z_q, 0);
        chk("clr_hi", hi_q, 0);
        chk("clr_lo", lo_q, 0);
        chk("clr_r2", r2_q, 0);
        chk("clr_r3", r3_q, 0);
        chk("clr_r4", r4_q, 0);
        chk("clr_r6", r6_q, 0);
        chk("clr_r7", r7_q, 0);
        mdr_load(32'h55);
        chk("post_rst_mdr", mdr_q, 64'h55);
        mdr_out = 1; r7_enable = 1; pc_increment = 1; tick();
        chk("post_rst_r7", r7_q, 64'h55);
        chk("post_rst_pc", pc_q, 64'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
